// File: rtl/fixed_point_mac_lanes.sv
// Multi-lane pipelined signed fixed-point multiplier with selectable rounding,
// saturation, optional per-lane accumulation and valid/ready flow control.

module fixed_point_mac_lane #(
  parameter int WIDTH     = 14,
  parameter int FRAC_BITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld1,
  input  logic                    ld2,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [1:0]              round_mode,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic signed [WIDTH-1:0] result,
  output logic                    sat_flag
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW:0] QMAX = {{(PW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] QMIN = {{(PW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] RMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] RMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    ax, bx, prod;
  logic signed [PW:0]      t, q;
  logic                    h, s, inc;
  logic signed [WIDTH-1:0] pr, acc, sval, nxt_res;
  logic signed [WIDTH:0]   sum;
  logic                    psat, ssat, nxt_sat;

  always_comb begin
    ax = {{WIDTH{a[WIDTH-1]}}, a};
    bx = {{WIDTH{b[WIDTH-1]}}, b};
  end

  // S1: full-precision product; the low 2*WIDTH bits of the sign-extended
  // product are exact since |a*b| always fits.
  always_ff @(posedge clk) begin
    if (!rst)     prod <= '0;
    else if (ld1) prod <= ax * bx;
  end

  // Floor-based rounding at 2*WIDTH+1 bits so the increment can never wrap.
  always_comb begin
    t = $signed({prod[PW-1], prod}) >>> FRAC_BITS;
    h = prod[FRAC_BITS-1];
    s = |prod[FRAC_BITS-2:0];
    case (round_mode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = h;
      default: inc = h & (s | t[0]);
    endcase
    q = t + {{PW{1'b0}}, inc};
    psat = 1'b1;
    if (q > QMAX)      pr = RMAX;
    else if (q < QMIN) pr = RMIN;
    else begin
      pr   = q[WIDTH-1:0];
      psat = 1'b0;
    end
  end

  always_comb begin
    sum  = {acc[WIDTH-1], acc} + {pr[WIDTH-1], pr};
    ssat = sum[WIDTH] ^ sum[WIDTH-1];
    sval = ssat ? (sum[WIDTH] ? RMIN : RMAX) : sum[WIDTH-1:0];
    nxt_res = pr;
    nxt_sat = psat;
    if (acc_en && !acc_clr) begin
      nxt_res = sval;
      nxt_sat = psat | ssat;
    end
  end

  // S2: output register; accumulator moves only when a beat enters S2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result   <= '0;
      sat_flag <= 1'b0;
      acc      <= '0;
    end else if (ld2) begin
      result   <= nxt_res;
      sat_flag <= nxt_sat;
      if (acc_en) acc <= nxt_res;
    end
  end
endmodule

module fixed_point_mac_lanes #(
  parameter int WIDTH     = 14,
  parameter int FRAC_BITS = 7,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [1:0]             round_mode,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       sat_flag
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [1:0] round_mode;
    logic       acc_en;
    logic       acc_clr;
  } ctl_t;

  logic [STAGES:1] vld_pipe;
  ctl_t            s1_ctl;
  logic            s1_adv, s2_adv, ld1;

  assign out_valid = vld_pipe[2];
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = vld_pipe[1] && s2_adv;
  assign in_ready  = rst && (!vld_pipe[1] || s2_adv);
  assign ld1       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_ctl   <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
      if (ld1)      s1_ctl      <= '{round_mode: round_mode, acc_en: acc_en, acc_clr: acc_clr};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fixed_point_mac_lane #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .ld1        (ld1),
      .ld2        (s1_adv),
      .a          (a[l*WIDTH +: WIDTH]),
      .b          (b[l*WIDTH +: WIDTH]),
      .round_mode (s1_ctl.round_mode),
      .acc_en     (s1_ctl.acc_en),
      .acc_clr    (s1_ctl.acc_clr),
      .result     (result[l*WIDTH +: WIDTH]),
      .sat_flag   (sat_flag[l])
    );
  end
endmodule
